// File: rtl/keypad_lock_if.sv
// -----------------------------------------------------------------------------
// keypad_lock_if
// Bundles the key-event input and the lock status outputs of keypad_lock_fsm.
//   master : key source (drives key_valid/key_code, observes status)
//   slave  : passcode engine (consumes keys, drives status)
// Signals:
//   key_valid  one-cycle pulse, key_code valid this cycle
//   key_code   KW-bit key value (0-15 digits, ENTER/CLEAR/SET, others ignored)
//   entry      DIGITS*4-bit current digit window, newest digit in [3:0]
//   count      digits held in entry (0..DIGITS)
//   unlocked   high in OPEN or SETCODE
//   alarm      high in ALARM
//   fails      consecutive failed attempts
//   state      00 LOCKED, 01 OPEN, 10 SETCODE, 11 ALARM
// -----------------------------------------------------------------------------
interface keypad_lock_if #(
  parameter int DIGITS = 4,
  parameter int KW     = 5
);
  logic                  key_valid;
  logic [KW-1:0]         key_code;
  logic [DIGITS*4-1:0]   entry;
  logic [3:0]            count;
  logic                  unlocked;
  logic                  alarm;
  logic [3:0]            fails;
  logic [1:0]            state;

  modport master (
    output key_valid, key_code,
    input  entry, count, unlocked, alarm, fails, state
  );

  modport slave (
    input  key_valid, key_code,
    output entry, count, unlocked, alarm, fails, state
  );
endinterface

// File: rtl/keypad_lock_fsm.sv
// -----------------------------------------------------------------------------
// keypad_lock_fsm
// Passcode engine for the keypad door lock. Collects hex digits into a sliding
// window, compares the window against the stored code on ENTER, opens the lock
// for UNLOCK_CYC cycles, lets the user change the code from the open state,
// and locks out all keys for LOCKOUT_CYC cycles after MAX_FAILS wrong entries.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset (code reverts to DEFAULT_CODE)
//   kp    keypad_lock_if.slave: key_valid/key_code in; entry, count,
//         unlocked, alarm, fails, state out (all driven from registers)
// -----------------------------------------------------------------------------
module keypad_lock_fsm #(
  parameter int                    DIGITS       = 4,
  parameter int                    KW           = 5,
  parameter int                    MAX_FAILS    = 3,
  parameter int                    UNLOCK_CYC   = 300,
  parameter int                    LOCKOUT_CYC  = 500,
  parameter logic [KW-1:0]         ENTER_KEY    = 5'd16,
  parameter logic [KW-1:0]         CLEAR_KEY    = 5'd17,
  parameter logic [KW-1:0]         SET_KEY      = 5'd18,
  parameter logic [DIGITS*4-1:0]   DEFAULT_CODE = 16'h1234
) (
  input  logic          clk,
  input  logic          rst,
  keypad_lock_if.slave  kp
);

  localparam int EW   = DIGITS * 4;
  localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  typedef enum logic [1:0] {
    ST_LOCKED = 2'b00,
    ST_OPEN   = 2'b01,
    ST_SET    = 2'b10,
    ST_ALARM  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic [3:0]      fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [EW-1:0]   code_q,  code_d;

  logic            key_dig, key_ent, key_clr, key_set;
  logic [EW+3:0]   shift_w;
  logic [3:0]      fails_inc;
  logic            entry_full;

  // Key decode; undefined codes fall through all four flags.
  assign key_dig = kp.key_valid && (int'(kp.key_code) < 16);
  assign key_ent = kp.key_valid && (kp.key_code == ENTER_KEY);
  assign key_clr = kp.key_valid && (kp.key_code == CLEAR_KEY);
  assign key_set = kp.key_valid && (kp.key_code == SET_KEY);

  // Window shift keeps the low EW bits so the oldest digit drops off the top.
  assign shift_w    = {entry_q, kp.key_code[3:0]};
  assign entry_full = (count_q == 4'(DIGITS));
  assign fails_inc  = (fails_q == 4'hF) ? fails_q : fails_q + 4'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOCKED;
      entry_q <= '0;
      count_q <= '0;
      fails_q <= '0;
      timer_q <= '0;
      code_q  <= DEFAULT_CODE;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    fails_d = fails_q;
    timer_d = timer_q;
    code_d  = code_q;

    unique case (state_q)
      ST_LOCKED: begin
        if (key_dig) begin
          entry_d = shift_w[EW-1:0];
          count_d = entry_full ? count_q : count_q + 4'd1;
        end else if (key_clr) begin
          entry_d = '0;
          count_d = '0;
        end else if (key_ent) begin
          entry_d = '0;
          count_d = '0;
          if (entry_full && (entry_q == code_q)) begin
            state_d = ST_OPEN;
            fails_d = '0;
            timer_d = '0;
          end else begin
            fails_d = fails_inc;
            if (fails_inc == 4'(MAX_FAILS)) begin
              state_d = ST_ALARM;
              timer_d = '0;
            end
          end
        end
      end

      ST_OPEN: begin
        // Relock timeout wins over a SET key landing on the final open cycle.
        if (timer_q == TW'(UNLOCK_CYC - 1)) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
          if (key_set) begin
            state_d = ST_SET;
            entry_d = '0;
            count_d = '0;
          end
        end
      end

      ST_SET: begin
        if (key_dig) begin
          entry_d = shift_w[EW-1:0];
          count_d = entry_full ? count_q : count_q + 4'd1;
        end else if (key_clr) begin
          state_d = ST_LOCKED;
          entry_d = '0;
          count_d = '0;
        end else if (key_ent && entry_full) begin
          code_d  = entry_q;
          state_d = ST_LOCKED;
          entry_d = '0;
          count_d = '0;
        end
      end

      ST_ALARM: begin
        if (timer_q == TW'(LOCKOUT_CYC - 1)) begin
          state_d = ST_LOCKED;
          fails_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = ST_LOCKED;
    endcase
  end

  // Outputs: straight from registers or decoded from the registered state
  always_comb begin
    kp.entry    = entry_q;
    kp.count    = count_q;
    kp.fails    = fails_q;
    kp.state    = state_q;
    kp.unlocked = (state_q == ST_OPEN) || (state_q == ST_SET);
    kp.alarm    = (state_q == ST_ALARM);
  end

endmodule

// File: tb/tb_keypad_lock_fsm.sv
module tb_keypad_lock_fsm;

  localparam int D     = 4;
  localparam int MAXF  = 3;
  localparam int UCYC  = 300;
  localparam int LCYC  = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  keypad_lock_if #(.DIGITS(D), .KW(5)) kp_if ();

  keypad_lock_fsm dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  always #5 clk = ~clk;

  // Reference model: digits kept as a queue (oldest first), code as a digit list,
  // time spent in OPEN/ALARM as a plain cycle counter.
  int m_state;   // 0 locked, 1 open, 2 setcode, 3 alarm
  int m_q[$];
  int m_code[$];
  int m_fails;
  int m_timer;

  function automatic void m_reset();
    m_state = 0;
    m_q.delete();
    m_code = {1, 2, 3, 4};
    m_fails = 0;
    m_timer = 0;
  endfunction

  function automatic bit m_match();
    if (m_q.size() != D) return 1'b0;
    for (int i = 0; i < D; i++)
      if (m_q[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_push(int k);
    m_q.push_back(k);
    if (m_q.size() > D) void'(m_q.pop_front());
  endfunction

  function automatic void m_step(bit v, int k);
    bit dig, ent, clr, st;
    dig = v && (k < 16);
    ent = v && (k == 16);
    clr = v && (k == 17);
    st  = v && (k == 18);
    case (m_state)
      0: begin
        if (dig) m_push(k);
        else if (clr) m_q.delete();
        else if (ent) begin
          if (m_match()) begin
            m_state = 1; m_fails = 0; m_timer = 0;
          end else begin
            if (m_fails < 15) m_fails++;
            if (m_fails == MAXF) begin m_state = 3; m_timer = 0; end
          end
          m_q.delete();
        end
      end
      1: begin
        m_timer++;
        if (m_timer == UCYC) m_state = 0;
        else if (st) begin m_state = 2; m_q.delete(); end
      end
      2: begin
        if (dig) m_push(k);
        else if (clr) begin m_q.delete(); m_state = 0; end
        else if (ent && m_q.size() == D) begin
          m_code = m_q;
          m_q.delete();
          m_state = 0;
        end
      end
      default: begin
        m_timer++;
        if (m_timer == LCYC) begin m_state = 0; m_fails = 0; end
      end
    endcase
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] e;
    e = 0;
    foreach (m_q[i]) e = (e << 4) | 64'(m_q[i]);
    return {28'd0, 2'(m_state), (m_state == 1 || m_state == 2), (m_state == 3),
            4'(m_fails), 4'(m_q.size()), e[15:0]};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {28'd0, kp_if.state, kp_if.unlocked, kp_if.alarm,
            kp_if.fails, kp_if.count, kp_if.entry};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle with the given key inputs; model advances, full output vector compared.
  task automatic cyc(input bit v, input int k);
    kp_if.key_valid = v;
    kp_if.key_code  = 5'(k);
    @(posedge clk);
    m_step(v, k);
    #1;
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, $urandom_range(0, 31));
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    cyc(1'b1, a); cyc(1'b1, b); cyc(1'b1, c); cyc(1'b1, d); cyc(1'b1, 16);
  endtask

  // Reset asserted between edges; values are checked before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    kp_if.key_valid = 1'b0;
    #1;
    m_reset();
    chk("rst_vec", dut_vec(), model_vec());
    chk("rst_state", kp_if.state, 2'b00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    kp_if.key_valid = 1'b0;
    kp_if.key_code  = '0;
    m_reset();
    do_reset();
    chk("rst_entry", kp_if.entry, 16'h0000);
    chk("rst_fails", kp_if.fails, 4'd0);

    // 1: correct code opens, relocks after exactly UCYC cycles
    code4(1, 2, 3, 4);
    chk("t1_state", kp_if.state, 2'b01);
    chk("t1_unl", kp_if.unlocked, 1'b1);
    chk("t1_fails", kp_if.fails, 4'd0);
    idle(UCYC - 1);
    chk("t1_still_open", kp_if.state, 2'b01);
    idle(1);
    chk("t1_relock", kp_if.state, 2'b00);

    // 2: five digits slide the window; short entry fails
    do_reset();
    cyc(1'b1, 9); cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b1, 3); cyc(1'b1, 4);
    chk("t2_entry", kp_if.entry, 16'h1234);
    chk("t2_count", kp_if.count, 4'd4);
    cyc(1'b1, 16);
    chk("t2_open", kp_if.state, 2'b01);
    idle(UCYC);
    cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b1, 16);
    chk("t2_fails", kp_if.fails, 4'd1);
    chk("t2_locked", kp_if.state, 2'b00);

    // 3: alarm after three failures, keys ignored, lockout duration
    do_reset();
    code4(1, 1, 1, 1); code4(2, 2, 2, 2); code4(3, 3, 3, 3);
    chk("t3_alarm", kp_if.alarm, 1'b1);
    chk("t3_state", kp_if.state, 2'b11);
    code4(1, 2, 3, 4);
    chk("t3_ignored", kp_if.state, 2'b11);
    idle(LCYC - 6);
    chk("t3_still_alarm", kp_if.state, 2'b11);
    idle(1);
    chk("t3_unlock_state", kp_if.state, 2'b00);
    chk("t3_fails0", kp_if.fails, 4'd0);
    code4(1, 2, 3, 4);
    chk("t3_open", kp_if.state, 2'b01);

    // 4: code change, old code rejected, aborted change keeps code
    do_reset();
    code4(1, 2, 3, 4);
    cyc(1'b1, 18);
    chk("t4_set", kp_if.state, 2'b10);
    code4(5, 6, 7, 8);
    chk("t4_locked", kp_if.state, 2'b00);
    code4(1, 2, 3, 4);
    chk("t4_old_fails", kp_if.fails, 4'd1);
    code4(5, 6, 7, 8);
    chk("t4_new_open", kp_if.state, 2'b01);
    cyc(1'b1, 18); cyc(1'b1, 5); cyc(1'b1, 17);
    chk("t4_abort", kp_if.state, 2'b00);
    code4(5, 6, 7, 8);
    chk("t4_kept", kp_if.state, 2'b01);

    // 5: short ENTER in SETCODE ignored; reset restores default code
    do_reset();
    code4(1, 2, 3, 4);
    cyc(1'b1, 18); cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b1, 16);
    chk("t5_stay", kp_if.state, 2'b10);
    chk("t5_entry", kp_if.entry, 16'h0012);
    do_reset();
    code4(1, 2, 3, 4);
    chk("t5_default", kp_if.state, 2'b01);

    // 6: success clears failure count
    do_reset();
    code4(9, 9, 9, 9); code4(9, 9, 9, 8);
    chk("t6_fails2", kp_if.fails, 4'd2);
    code4(1, 2, 3, 4);
    chk("t6_open", kp_if.state, 2'b01);
    chk("t6_fails0", kp_if.fails, 4'd0);
    idle(UCYC);
    code4(9, 9, 9, 9);
    chk("t6_fails1", kp_if.fails, 4'd1);
    chk("t6_no_alarm", kp_if.state, 2'b00);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 1) do_reset();
      else if (r < 4) idle($urandom_range(50, 300));
      else if (r < 24) begin
        int cd[$];
        cd = m_code;
        for (int i = 0; i < D; i++) cyc(1'b1, cd[i]);
        cyc(1'b1, 16);
      end
      else if (r < 34) cyc(1'b1, 18);
      else if (r < 64) cyc(1'b1, 16);
      else if (r < 80) cyc(1'b1, 17);
      else if (r < 96) cyc(1'b1, $urandom_range(19, 31));
      else if (r < 126) cyc(1'b0, $urandom_range(0, 31));
      else cyc(1'b1, $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
